// File: rtl/pe_instr_fetch.sv
// Instruction fetch stage feeding the PE instruction register: one outstanding imem read,
// small prefetch FIFO, stall/branch handling. Optional perf counters under FETCH_PERF_CNT_EN.
module pe_instr_fetch #(
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [31:0] i_boot_pc,
    input  logic        i_stall,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_ir_load,
    output logic [31:0] o_ir_data,
    output logic [31:0] o_ir_pc,
    output logic        o_busy
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] o_perf_fetch_cnt,
    output logic [15:0] o_perf_flush_cnt
`endif
);

    localparam int          AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t         r_state;
    logic [31:0]    r_fetch_pc;
    logic [31:0]    r_req_pc;
    logic           r_outstanding;
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic [31:0]    r_fifo_data [FIFO_DEPTH];
    logic [31:0]    r_fifo_pc   [FIFO_DEPTH];

    logic w_run;
    logic w_empty;
    logic w_req;
    logic w_accept;
    logic w_rsp;
    logic w_push;
    logic w_pop;
    logic w_branch_run;
    logic w_discard;

    assign w_run        = (r_state == S_RUN);
    assign w_empty      = (r_count == '0);
    assign w_req        = w_run && !r_outstanding && (r_count < DEPTH_C) && !i_branch_taken;
    assign w_accept     = w_req && i_imem_gnt;
    assign w_rsp        = r_outstanding && i_imem_rvalid;
    assign w_push       = w_run && w_rsp && !i_branch_taken;
    assign w_pop        = w_run && !w_empty && !i_stall && !i_branch_taken;
    assign w_branch_run = w_run && i_branch_taken;
    // A response landing in FLUSH, or in the very cycle of a redirect, belongs to the old stream.
    assign w_discard    = w_rsp && ((r_state == S_FLUSH) || w_branch_run);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_fetch_pc    <= RESET_PC;
            r_req_pc      <= '0;
            r_outstanding <= 1'b0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
        end else begin
            if (w_accept) begin
                r_outstanding <= 1'b1;
                r_req_pc      <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + 32'd4;
            end else if (w_rsp) begin
                r_outstanding <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state    <= S_RUN;
                        r_fetch_pc <= {i_boot_pc[31:2], 2'b00};
                    end else if (i_branch_taken) begin
                        r_fetch_pc <= {i_branch_target[31:2], 2'b00};
                    end
                end
                S_RUN: begin
                    if (i_branch_taken) begin
                        r_fetch_pc <= {i_branch_target[31:2], 2'b00};
                        // Wait out a response still owed; one arriving right now is dropped here.
                        if ((r_outstanding && !i_imem_rvalid) || w_accept)
                            r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (i_branch_taken)
                        r_fetch_pc <= {i_branch_target[31:2], 2'b00};
                    if (w_rsp)
                        r_state <= S_RUN;
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_branch_run) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            end
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
            always_ff @(posedge i_clock) begin
                if (w_push && (r_wr_ptr == AW'(gi))) begin
                    r_fifo_data[gi] <= i_imem_rdata;
                    r_fifo_pc[gi]   <= r_req_pc;
                end
            end
        end
    endgenerate

    assign o_imem_req  = w_req;
    assign o_imem_addr = r_fetch_pc;
    assign o_ir_load   = w_pop;
    assign o_ir_data   = w_empty ? 32'd0 : r_fifo_data[r_rd_ptr];
    assign o_ir_pc     = w_empty ? 32'd0 : r_fifo_pc[r_rd_ptr];
    assign o_busy      = (r_state != S_IDLE);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetch_cnt;
    logic [15:0] r_perf_flush_cnt;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_perf_fetch_cnt <= '0;
            r_perf_flush_cnt <= '0;
        end else begin
            if (w_pop)
                r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
            if (w_discard && (r_perf_flush_cnt != 16'hFFFF))
                r_perf_flush_cnt <= r_perf_flush_cnt + 16'd1;
        end
    end

    assign o_perf_fetch_cnt = r_perf_fetch_cnt;
    assign o_perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule
